// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared state encoding and width helpers for the SVM alpha accumulator
package svm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Wide enough to sum depth worst-case products without overflow, plus a sign bit.
  function automatic int acc_width(input int alpha_w, input int kernel_w, input int depth);
    return alpha_w + kernel_w + clog2(depth) + 1;
  endfunction

  localparam int ACC_WIDTH = acc_width(12, 12, 100);

endpackage

// File: rtl/svm_alpha_accumulator_if.sv
// rtl/svm_alpha_accumulator_if.sv - alpha/kernel beat stream into the accumulator
interface svm_alpha_accumulator_if #(
  parameter int alphaWidth  = 12,
  parameter int kernelWidth = 12
);
  logic                          in_valid;
  logic signed [alphaWidth-1:0]  alpha;
  logic signed [kernelWidth-1:0] kernel;
  logic                          group_end;
  logic                          last_in;

  modport master (output in_valid, alpha, kernel, group_end, last_in);
  modport slave  (input  in_valid, alpha, kernel, group_end, last_in);
endinterface

// File: rtl/svm_mac_stage.sv
// rtl/svm_mac_stage.sv - registered signed multiply followed by sign-extending accumulate
module svm_mac_stage #(
  parameter int alphaWidth  = 12,
  parameter int kernelWidth = 12,
  parameter int accWidth    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic signed [alphaWidth-1:0]  alpha,
  input  logic signed [kernelWidth-1:0] kernel,
  output logic signed [accWidth-1:0]    acc,
  output logic                          acc_final
);
  localparam int PW = alphaWidth + kernelWidth;

  logic signed [PW-1:0] product;
  logic                 s1_valid;
  logic                 s1_last;

  // Stage 1: full-width product; valid/last ride alongside so gaps leave the accumulator untouched.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      product  <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      if (in_valid) begin
        product <= alpha * kernel;
      end
    end
  end

  // Stage 2: sign-extend and accumulate; acc_final marks the cycle acc holds the complete sum.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc       <= '0;
      acc_final <= 1'b0;
    end else begin
      acc_final <= s1_valid & s1_last;
      if (s1_valid) begin
        acc <= acc + {{(accWidth - PW){product[PW-1]}}, product};
      end
    end
  end

endmodule

// File: rtl/svm_alpha_accumulator.sv
// rtl/svm_alpha_accumulator.sv - accumulates alpha*kernel over a stream and emits score and decision
module svm_alpha_accumulator
  import svm_pkg::*;
#(
  parameter int maxColumn     = 100,
  parameter int alphaWidth    = 12,
  parameter int kernelWidth   = 12,
  parameter int alphaMemDepth = 100,
  parameter int accWidth      = acc_width(alphaWidth, kernelWidth, alphaMemDepth)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  svm_alpha_accumulator_if.slave           beat,
  input  logic signed [accWidth-1:0]       bias,
  output logic                             result_valid,
  output logic signed [accWidth-1:0]       score,
  output logic                             decision,
  output logic [clog2(alphaMemDepth):0]    groups_done,
  output logic                             count_error,
  output logic                             busy
);
  localparam int CW = clog2(alphaMemDepth) + 1;
  // A well-formed stream closes at most this many groups; stray markers cannot push the count past it.
  localparam int GROUP_LIMIT = (alphaMemDepth + maxColumn - 1) / maxColumn;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(alphaMemDepth);

  state_t                      state;
  state_t                      state_nxt;
  logic                        drain_cnt;
  logic                        accept;
  logic [CW-1:0]               beat_cnt;
  logic signed [accWidth-1:0]  acc;
  logic                        acc_final;
  logic signed [accWidth-1:0]  final_sum;

  svm_mac_stage #(
    .alphaWidth (alphaWidth),
    .kernelWidth(kernelWidth),
    .accWidth   (accWidth)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .in_valid (accept),
    .in_last  (beat.last_in),
    .alpha    (beat.alpha),
    .kernel   (beat.kernel),
    .acc      (acc),
    .acc_final(acc_final)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain timer: DRAIN covers the two cycles the final beat needs to reach the accumulator.
  always_ff @(posedge clock) begin
    if (reset || clear || state != ST_DRAIN) begin
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= ~drain_cnt;
    end
  end

  // Next-state logic; clear overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nxt = beat.last_in ? ST_DRAIN : ST_ACCUM;
        ST_ACCUM: if (accept && beat.last_in) state_nxt = ST_DRAIN;
        ST_DRAIN: if (drain_cnt) state_nxt = ST_DONE;
        default:  state_nxt = ST_DONE;
      endcase
    end
  end

  // Output decode: beats are only taken before the final one, so a held last_in finalises once.
  always_comb begin
    accept = beat.in_valid && !clear && (state == ST_IDLE || state == ST_ACCUM);
    busy   = (state == ST_ACCUM && beat_cnt != '0) || state == ST_DRAIN || state == ST_DONE;
  end

  // Beat and group counters plus the length check taken at the final beat.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      beat_cnt    <= '0;
      groups_done <= '0;
      count_error <= 1'b0;
    end else if (accept) begin
      if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (beat.group_end && groups_done < CW'(GROUP_LIMIT)) begin
        groups_done <= groups_done + 1'b1;
      end
      if (beat.last_in && (({1'b0, beat_cnt} + 1'b1) != DEPTH_W)) begin
        count_error <= 1'b1;
      end
    end
  end

  assign final_sum = acc + bias;

  // Final stage: bias is added once the last product is in; score and decision then hold.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      result_valid <= 1'b0;
      score        <= '0;
      decision     <= 1'b0;
    end else begin
      result_valid <= acc_final;
      if (acc_final) begin
        score    <= final_sum;
        decision <= ~final_sum[accWidth-1];
      end
    end
  end

endmodule

// File: tb/tb_svm_alpha_accumulator.sv
// tb/tb_svm_alpha_accumulator.sv - directed self-checking bench for svm_alpha_accumulator
module tb_svm_alpha_accumulator;
  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               clear = 1'b0;
  logic signed [27:0] bias  = '0;
  logic               result_valid;
  logic signed [27:0] score;
  logic               decision;
  logic [3:0]         groups_done;
  logic               count_error;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rv_total = 0;
  int rv_cycle = 0;
  int beat_cyc = 0;
  int final_cyc = 0;
  int base;

  svm_alpha_accumulator_if #(.alphaWidth(12), .kernelWidth(12)) bi ();

  svm_alpha_accumulator #(
    .maxColumn(4), .alphaWidth(12), .kernelWidth(12), .alphaMemDepth(8)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear), .beat(bi), .bias(bias),
    .result_valid(result_valid), .score(score), .decision(decision),
    .groups_done(groups_done), .count_error(count_error), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (result_valid) begin
      rv_total <= rv_total + 1;
      rv_cycle <= cyc;
    end
  end

  task automatic beat_in(input logic signed [11:0] a, input logic signed [11:0] k,
                         input logic ge, input logic li);
    bi.in_valid = 1'b1; bi.alpha = a; bi.kernel = k; bi.group_end = ge; bi.last_in = li;
    @(posedge clock); #1;
    beat_cyc = cyc;
  endtask

  task automatic idle(input int n);
    bi.in_valid = 1'b0; bi.group_end = 1'b0; bi.last_in = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_clear();
    bi.in_valid = 1'b0; clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic stream(input int n, input logic signed [11:0] a, input logic signed [11:0] k,
                        input int gap);
    for (int i = 0; i < n; i++) begin
      beat_in(a, k, (i % 4) == 3, i == n - 1);
      if (i == n - 1) final_cyc = beat_cyc;
      if (gap != 0 && i != n - 1) idle(gap);
    end
    bi.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid: got %0b expected 0", result_valid); end
    vectors++; if (score !== 28'sd0) begin miscompares++; $display("FAIL reset_score: got %0d expected 0", score); end
    vectors++; if (decision !== 1'b0) begin miscompares++; $display("FAIL reset_decision: got %0b expected 0", decision); end
    vectors++; if (groups_done !== 4'd0) begin miscompares++; $display("FAIL reset_groups_done: got %0d expected 0", groups_done); end
    vectors++; if (count_error !== 1'b0) begin miscompares++; $display("FAIL reset_count_error: got %0b expected 0", count_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    bias = -28'sd10;
    base = rv_total;
    stream(8, 12'sd1, 12'sd2, 0);
    idle(5);
    vectors++; if (rv_total - base !== 1) begin miscompares++; $display("FAIL basic_pulses: got %0d expected 1", rv_total - base); end
    vectors++; if (rv_cycle !== final_cyc + 2) begin miscompares++; $display("FAIL basic_latency: got cycle %0d expected %0d", rv_cycle, final_cyc + 2); end
    vectors++; if (score !== 28'sd6) begin miscompares++; $display("FAIL basic_score: got %0d expected 6", score); end
    vectors++; if (decision !== 1'b1) begin miscompares++; $display("FAIL basic_decision: got %0b expected 1", decision); end
    vectors++; if (groups_done !== 4'd2) begin miscompares++; $display("FAIL basic_groups: got %0d expected 2", groups_done); end
    vectors++; if (count_error !== 1'b0) begin miscompares++; $display("FAIL basic_count_error: got %0b expected 0", count_error); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_done: got %0b expected 1", busy); end
    do_clear();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy: got %0b expected 0", busy); end
    vectors++; if (score !== 28'sd0) begin miscompares++; $display("FAIL clear_score: got %0d expected 0", score); end
  endtask

  task automatic test_negative();
    bias = 28'sd0;
    stream(8, -12'sd3, 12'sd5, 0);
    idle(5);
    vectors++; if (score !== -28'sd120) begin miscompares++; $display("FAIL neg_score: got %0d expected -120", score); end
    vectors++; if (decision !== 1'b0) begin miscompares++; $display("FAIL neg_decision: got %0b expected 0", decision); end
    do_clear();
  endtask

  task automatic test_extremes();
    bias = 28'sd0;
    stream(8, -12'sd2048, -12'sd2048, 0);
    idle(5);
    vectors++; if (score !== 28'sd33554432) begin miscompares++; $display("FAIL ext_score: got %0d expected 33554432", score); end
    vectors++; if (decision !== 1'b1) begin miscompares++; $display("FAIL ext_decision: got %0b expected 1", decision); end
    do_clear();
  endtask

  task automatic test_held_last();
    bias = -28'sd10;
    base = rv_total;
    stream(8, 12'sd1, 12'sd2, 0);
    for (int j = 0; j < 5; j++) beat_in(12'sd1, 12'sd2, 1'b1, 1'b1);
    idle(6);
    vectors++; if (rv_total - base !== 1) begin miscompares++; $display("FAIL held_pulses: got %0d expected 1", rv_total - base); end
    vectors++; if (score !== 28'sd6) begin miscompares++; $display("FAIL held_score: got %0d expected 6", score); end
    vectors++; if (groups_done !== 4'd2) begin miscompares++; $display("FAIL held_groups: got %0d expected 2", groups_done); end
    do_clear();
  endtask

  task automatic test_gaps();
    bias = -28'sd10;
    base = rv_total;
    stream(8, 12'sd1, 12'sd2, 1);
    idle(5);
    vectors++; if (rv_total - base !== 1) begin miscompares++; $display("FAIL gaps_pulses: got %0d expected 1", rv_total - base); end
    vectors++; if (score !== 28'sd6) begin miscompares++; $display("FAIL gaps_score: got %0d expected 6", score); end
    do_clear();
  endtask

  task automatic test_short();
    bias = -28'sd10;
    stream(6, 12'sd1, 12'sd2, 0);
    idle(5);
    vectors++; if (score !== 28'sd2) begin miscompares++; $display("FAIL short_score: got %0d expected 2", score); end
    vectors++; if (count_error !== 1'b1) begin miscompares++; $display("FAIL short_count_error: got %0b expected 1", count_error); end
    vectors++; if (groups_done !== 4'd1) begin miscompares++; $display("FAIL short_groups: got %0d expected 1", groups_done); end
    do_clear();
    vectors++; if (count_error !== 1'b0) begin miscompares++; $display("FAIL short_error_cleared: got %0b expected 0", count_error); end
  endtask

  task automatic test_single_beat();
    bias = 28'sd0;
    base = rv_total;
    beat_in(12'sd3, 12'sd4, 1'b0, 1'b1);
    idle(5);
    vectors++; if (rv_total - base !== 1) begin miscompares++; $display("FAIL single_pulses: got %0d expected 1", rv_total - base); end
    vectors++; if (score !== 28'sd12) begin miscompares++; $display("FAIL single_score: got %0d expected 12", score); end
    vectors++; if (count_error !== 1'b1) begin miscompares++; $display("FAIL single_count_error: got %0b expected 1", count_error); end
    do_clear();
  endtask

  task automatic test_reset_mid();
    bias = 28'sd0;
    base = rv_total;
    for (int i = 0; i < 4; i++) beat_in(12'sd1, 12'sd2, (i % 4) == 3, 1'b0);
    bi.in_valid = 1'b0;
    reset = 1'b1;
    idle(2);
    vectors++; if (score !== 28'sd0 || decision !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_outputs: got score %0d dec %0b rv %0b expected 0 0 0", score, decision, result_valid); end
    vectors++; if (groups_done !== 4'd0 || count_error !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_status: got groups %0d err %0b busy %0b expected 0 0 0", groups_done, count_error, busy); end
    reset = 1'b0;
    stream(8, -12'sd3, 12'sd5, 0);
    idle(5);
    vectors++; if (rv_total - base !== 1) begin miscompares++; $display("FAIL midreset_pulses: got %0d expected 1", rv_total - base); end
    vectors++; if (score !== -28'sd120) begin miscompares++; $display("FAIL midreset_score: got %0d expected -120", score); end
    do_clear();
  endtask

  task automatic test_clear_beat();
    bias = -28'sd10;
    bi.in_valid = 1'b1; bi.alpha = 12'sd100; bi.kernel = 12'sd100; bi.group_end = 1'b1; bi.last_in = 1'b0;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    bi.in_valid = 1'b0;
    vectors++; if (busy !== 1'b0 || groups_done !== 4'd0) begin miscompares++; $display("FAIL clearbeat_idle: got busy %0b groups %0d expected 0 0", busy, groups_done); end
    stream(8, 12'sd1, 12'sd2, 0);
    idle(5);
    vectors++; if (score !== 28'sd6) begin miscompares++; $display("FAIL clearbeat_score: got %0d expected 6", score); end
    do_clear();
  endtask

  task automatic test_clear_drain();
    bias = -28'sd10;
    base = rv_total;
    stream(8, 12'sd1, 12'sd2, 0);
    do_clear();
    idle(5);
    vectors++; if (rv_total - base !== 0) begin miscompares++; $display("FAIL drainclear_pulses: got %0d expected 0", rv_total - base); end
    vectors++; if (score !== 28'sd0 || busy !== 1'b0) begin miscompares++; $display("FAIL drainclear_state: got score %0d busy %0b expected 0 0", score, busy); end
  endtask

  initial begin
    bi.in_valid = 1'b0; bi.alpha = '0; bi.kernel = '0; bi.group_end = 1'b0; bi.last_in = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_held_last();
    test_gaps();
    test_short();
    test_single_beat();
    test_reset_mid();
    test_clear_beat();
    test_clear_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/svm_alpha_accumulator.md
Name: svm_alpha_accumulator

Overview:
- Consumer end of the SVM alpha-coefficient read stream. It takes the alpha words returned from alpha memory, the per-address group-end marker and the sticky last-scalar flag.
- Each beat, it multiplies alpha by the matching kernel value and accumulates the products over the whole alpha memory. At end of stream it adds bias and emits a signed score plus a binary decision.
- Sits between alpha memory / kernel datapath and the window-classification logic.

Parameters:
- maxColumn, 100, beats per group; group_end is expected on beat maxColumn-1 of each group.
- alphaWidth, 12, signed alpha coefficient width.
- kernelWidth, 12, signed kernel value width.
- alphaMemDepth, 100, expected beats per classification.
- accWidth, alphaWidth+kernelWidth+clog2(alphaMemDepth)+1, signed accumulator/score width (32 at defaults).

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  pulse; start new classification.
- in_valid  in  1  alpha/kernel/group_end/last_in valid this cycle.
- alpha  in  alphaWidth  signed coefficient.
- kernel  in  kernelWidth  signed kernel value.
- group_end  in  1  last beat of current group.
- last_in  in  1  sticky end-of-stream flag; may stay high on later beats.
- bias  in  accWidth  signed bias, sampled when the final sum is formed.
- result_valid  out  1  one-cycle pulse; score/decision valid.
- score  out  accWidth  signed final sum.
- decision  out  1  1 when score >= 0.
- groups_done  out  clog2(alphaMemDepth)+1  completed-group count.
- count_error  out  1  sticky; beat count at last_in was not alphaMemDepth.
- busy  out  1  high in ACCUM with at least one beat taken, in DRAIN, or in DONE.

Behaviour:
- Reset: all outputs 0, accumulator 0, beat counter 0, pipeline valid bits 0, state IDLE.
- States: IDLE, ACCUM, DRAIN, DONE.
  - IDLE -> ACCUM on first accepted beat.
  - ACCUM -> DRAIN on an accepted beat with last_in=1.
  - DRAIN lasts exactly 2 cycles -> DONE.
  - DONE -> IDLE only on clear or reset.
- Beat accepted when in_valid=1, clear=0, and state is IDLE or ACCUM.
  - Beats arriving in DRAIN or DONE are ignored; a held last_in therefore yields exactly one result.
- Pipeline, for an accepted beat at cycle t:
  - Stage 1: product = alpha*kernel, full signed width alphaWidth+kernelWidth, registered at t+1.
  - Stage 2: product sign-extended to accWidth, added to accumulator at t+2.
  - Stage 3 (final beat only): score = acc + bias and decision registered; result_valid high at t+3 for exactly one cycle.
  - score and decision hold until clear or reset.
- Arithmetic: two's complement throughout. No saturation; accWidth guarantees no overflow for alphaMemDepth worst-case products.
- Counters:
  - Beat counter increments per accepted beat.
  - groups_done increments on each accepted beat with group_end=1.
  - group_end and last_in on the same beat: count the group, then finalise.
- count_error: set at the final beat if beat count including that beat != alphaMemDepth. It is still set if this is the only beat, i.e. IDLE with last_in=1 (that beat is still processed normally). Cleared by clear or reset.
- in_valid gaps: the stage-1 valid bit is low and the accumulator holds.
- clear:
  - Zeroes the accumulator, counters, count_error, score, decision and pipeline valid bits, and returns to IDLE next cycle.
  - If clear coincides with in_valid, clear wins and the beat is dropped.
  - A clear during DRAIN aborts the result; no result_valid is produced.
- reset mid-operation: same as the reset values; no result_valid produced for the aborted stream.

Decomposition:
- Shared package svm_pkg holds:
  - the clog2 function;
  - the state encoding constants ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE;
  - the derived-width constant for accWidth.
- One natural sub-module: svm_mac_stage, the registered signed multiply plus sign-extending accumulate with valid pipelining. The FSM and counters stay in the top.

Test Plan (maxColumn=4, alphaMemDepth=8, accWidth=28 unless noted):
- 8 beats alpha=1, kernel=2, group_end on beats 3 and 7, last_in on beat 7, bias=-10 -> score=6, decision=1, groups_done=2, result_valid exactly at last beat +3, count_error=0.
- 8 beats alpha=-3, kernel=5, bias=0 -> score=-120, decision=0.
- Extremes: 8 beats alpha=-2048, kernel=-2048, bias=0 -> score=33554432, no overflow, decision=1.
- Same as the first case but last_in held high with in_valid for 5 extra beats -> single result_valid pulse, score stays 6, groups_done stays 2.
- Stream with 1-cycle in_valid gaps between every beat, values as in the first case -> identical score=6. Separately: last_in after 6 beats -> count_error=1, score=sum of 6 products plus bias.
- Reset asserted after beat 4, then a full stream as in the second case -> no result from the aborted stream, all outputs 0 during reset, then score=-120. Separately: clear concurrent with a valid beat -> that beat dropped, state IDLE.
